// File: rtl/regwb_arb_if.sv
// Writeback arbiter bus: two writeback requesters, issue/hazard-check port
// and the register file write port.
interface regwb_arb_if;
    logic        wb0_valid;
    logic [4:0]  wb0_reg;
    logic [31:0] wb0_data;
    logic        wb0_ready;

    logic        wb1_valid;
    logic [4:0]  wb1_reg;
    logic [31:0] wb1_data;
    logic        wb1_ready;

    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic [4:0]  chk_reg1;
    logic [4:0]  chk_reg2;
    logic        chk_busy1;
    logic        chk_busy2;

    logic        regwrite;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;

    modport master (
        output wb0_valid, wb0_reg, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_reg, wb1_data,
        input  wb1_ready,
        output iss_valid, iss_reg, chk_reg1, chk_reg2,
        input  chk_busy1, chk_busy2,
        input  regwrite, wrreg, wrdata
    );

    modport slave (
        input  wb0_valid, wb0_reg, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_reg, wb1_data,
        output wb1_ready,
        input  iss_valid, iss_reg, chk_reg1, chk_reg2,
        output chk_busy1, chk_busy2,
        output regwrite, wrreg, wrdata
    );
endinterface

// File: rtl/regwb_arb.sv
// Two-requester register-file writeback arbiter with starvation guard for
// requester 1 and a pending-write scoreboard for issue hazard checks.
module regwb_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input logic        clk,
    input logic        reset,
    regwb_arb_if.slave bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]  starve_cnt;
    logic        starve_hit;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [4:0]  acc_reg;
    logic [31:0] acc_data;

    logic        vld_p0;
    logic [4:0]  wrreg_p0;
    logic [31:0] wrdata_p0;

    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // A source is still hazardous unless the write retiring this cycle forwards it.
    function automatic logic hazard(input logic [4:0] r);
        return (r != 5'd0) && busy[r] && !(vld_p0 && (wrreg_p0 == r));
    endfunction

    always_comb begin
        starve_hit = bus.wb1_valid && (starve_cnt == LIMIT);
        grant1     = !reset && bus.wb1_valid && (starve_hit || !bus.wb0_valid);
        grant0     = !reset && bus.wb0_valid && !starve_hit;
        accept     = grant0 || grant1;
        acc_reg    = grant1 ? bus.wb1_reg  : bus.wb0_reg;
        acc_data   = grant1 ? bus.wb1_data : bus.wb0_data;
    end

    assign bus.wb0_ready = grant0;
    assign bus.wb1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (!bus.wb1_valid || grant1) begin
            starve_cnt <= 3'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Stage p0: accepted transfer registered onto the register file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            wrreg_p0  <= 5'd0;
            wrdata_p0 <= 32'd0;
        end else if (accept) begin
            vld_p0    <= (acc_reg != 5'd0);
            wrreg_p0  <= acc_reg;
            wrdata_p0 <= acc_data;
        end else begin
            vld_p0    <= 1'b0;
        end
    end

    assign bus.regwrite = vld_p0;
    assign bus.wrreg    = wrreg_p0;
    assign bus.wrdata   = wrdata_p0;

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (bus.iss_valid && (bus.iss_reg != 5'd0))
            set_mask[bus.iss_reg] = 1'b1;
        if (vld_p0)
            clr_mask[wrreg_p0] = 1'b1;
    end

    // Set is applied after clear so a same-edge issue keeps the register busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 32'd0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    assign bus.chk_busy1 = hazard(bus.chk_reg1);
    assign bus.chk_busy2 = hazard(bus.chk_reg2);
endmodule

// File: tb/tb_regwb_arb.sv
// Randomized plus directed bench for regwb_arb: driver feeds a reference
// model that queues expectations; a negedge monitor pops and compares.
module tb_regwb_arb;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regwb_arb_if bus ();

    regwb_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  c1;
        logic [4:0]  c2;
    } stim_t;

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        chk1;
        logic        chk2;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    exp_t eq[$];
    wr_t  wq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what has been issued, what is in flight, how long
    // requester 1 has been waiting.
    bit          busy_m [32];
    int          refused_m;
    bit          rw_m;
    logic [4:0]  wreg_m;
    logic [31:0] wdata_m;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (rw_m && wreg_m == r) return 1'b0;
        return busy_m[r];
    endfunction

    task automatic cyc(input stim_t s);
        exp_t       e;
        bit         g0, g1;
        logic [4:0] ar;
        logic [31:0] ad;
        @(posedge clk);
        #1;
        reset         = s.rst;
        bus.wb0_valid = s.v0;
        bus.wb0_reg   = s.r0;
        bus.wb0_data  = s.d0;
        bus.wb1_valid = s.v1;
        bus.wb1_reg   = s.r1;
        bus.wb1_data  = s.d1;
        bus.iss_valid = s.iv;
        bus.iss_reg   = s.ir;
        bus.chk_reg1  = s.c1;
        bus.chk_reg2  = s.c2;

        g1 = !s.rst && s.v1 && (refused_m >= LIMIT || !s.v0);
        g0 = !s.rst && s.v0 && !g1;

        e.rdy0  = g0;
        e.rdy1  = g1;
        e.chk1  = pending(s.c1);
        e.chk2  = pending(s.c2);
        e.rw    = rw_m;
        e.wreg  = wreg_m;
        e.wdata = wdata_m;
        eq.push_back(e);

        if (s.rst) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            refused_m = 0;
            rw_m      = 1'b0;
            wreg_m    = 5'd0;
            wdata_m   = 32'd0;
        end else begin
            if (rw_m) busy_m[wreg_m] = 1'b0;
            if (s.iv && s.ir != 5'd0) busy_m[s.ir] = 1'b1;
            if (g0 || g1) begin
                ar      = g1 ? s.r1 : s.r0;
                ad      = g1 ? s.d1 : s.d0;
                rw_m    = (ar != 5'd0);
                wreg_m  = ar;
                wdata_m = ad;
                if (ar != 5'd0) wq.push_back({ar, ad});
            end else begin
                rw_m = 1'b0;
            end
            if (!s.v1 || g1) refused_m = 0;
            else if (refused_m < LIMIT) refused_m = refused_m + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    exp_t me;
    wr_t  mw;

    always @(negedge clk) begin
        if (eq.size() > 0) begin
            me = eq.pop_front();
            chk("wb0_ready", 32'(bus.wb0_ready), 32'(me.rdy0));
            chk("wb1_ready", 32'(bus.wb1_ready), 32'(me.rdy1));
            chk("chk_busy1", 32'(bus.chk_busy1), 32'(me.chk1));
            chk("chk_busy2", 32'(bus.chk_busy2), 32'(me.chk2));
            chk("regwrite",  32'(bus.regwrite),  32'(me.rw));
            chk("wrreg",     32'(bus.wrreg),     32'(me.wreg));
            chk("wrdata",    bus.wrdata,         me.wdata);
            if (bus.regwrite === 1'b1) begin
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL write_order: unexpected write reg %0d data %h, none queued", bus.wrreg, bus.wrdata);
                end else begin
                    mw = wq.pop_front();
                    chk("write_reg",  32'(bus.wrreg), 32'(mw.r));
                    chk("write_data", bus.wrdata,     mw.d);
                end
            end
        end
    end

    initial begin
        stim_t s;
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        refused_m = 0;
        rw_m      = 1'b0;
        wreg_m    = 5'd0;
        wdata_m   = 32'd0;

        reset = 1'b1;
        bus.wb0_valid = 1'b0; bus.wb0_reg = 5'd0; bus.wb0_data = 32'd0;
        bus.wb1_valid = 1'b0; bus.wb1_reg = 5'd0; bus.wb1_data = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_reg = 5'd0;
        bus.chk_reg1  = 5'd0; bus.chk_reg2 = 5'd0;
        repeat (2) @(posedge clk);

        // Reset holds readies low even with both requesters valid.
        s = idle(); s.rst = 1; s.v0 = 1; s.r0 = 5'd1; s.v1 = 1; s.r1 = 5'd2; s.iv = 1; s.ir = 5'd3;
        cyc(s);

        // Single write.
        s = idle(); s.v0 = 1; s.r0 = 5'd5; s.d0 = 32'hDEADBEEF;
        cyc(s); cyc(idle()); cyc(idle());

        // Starvation: both requesters held valid.
        for (int i = 0; i < 12; i++) begin
            s = idle(); s.v0 = 1; s.r0 = 5'd10 + 5'(i % 4); s.d0 = $urandom;
            s.v1 = 1; s.r1 = 5'd20 + 5'(i % 4); s.d1 = $urandom;
            cyc(s);
        end
        cyc(idle());

        // Scoreboard: issue r7, watch it, retire via requester 1.
        s = idle(); s.iv = 1; s.ir = 5'd7; cyc(s);
        for (int i = 0; i < 3; i++) begin s = idle(); s.c1 = 5'd7; cyc(s); end
        s = idle(); s.c1 = 5'd7; s.v1 = 1; s.r1 = 5'd7; s.d1 = 32'h0000_0777; cyc(s);
        for (int i = 0; i < 3; i++) begin s = idle(); s.c1 = 5'd7; cyc(s); end

        // Same-edge set and clear on r9.
        s = idle(); s.iv = 1; s.ir = 5'd9; cyc(s);
        s = idle(); s.v0 = 1; s.r0 = 5'd9; s.d0 = 32'h9999_0000; s.c2 = 5'd9; cyc(s);
        s = idle(); s.iv = 1; s.ir = 5'd9; s.c1 = 5'd9; cyc(s);
        for (int i = 0; i < 2; i++) begin s = idle(); s.c1 = 5'd9; cyc(s); end

        // Register 0 traffic.
        s = idle(); s.v0 = 1; s.r0 = 5'd0; s.d0 = 32'h1234_5678; s.iv = 1; s.ir = 5'd0; cyc(s);
        s = idle(); s.c1 = 5'd0; s.c2 = 5'd0; cyc(s);

        // Reset mid-operation.
        s = idle(); s.iv = 1; s.ir = 5'd3; s.v1 = 1; s.r1 = 5'd12; cyc(s);
        s = idle(); s.iv = 1; s.ir = 5'd4; s.v0 = 1; s.r0 = 5'd4; s.d0 = 32'hCAFE_0004; s.v1 = 1; s.r1 = 5'd12; cyc(s);
        s = idle(); s.rst = 1; s.c1 = 5'd3; s.c2 = 5'd4; cyc(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.c1 = 5'd3; s.c2 = 5'd4; s.v0 = 1; s.r0 = 5'd1; s.d0 = $urandom;
            s.v1 = 1; s.r1 = 5'd2; s.d1 = $urandom;
            cyc(s);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst = ($urandom_range(0, 99) < 2);
            s.v0  = ($urandom_range(0, 99) < 55);
            s.r0  = rnd_reg();
            s.d0  = $urandom;
            s.v1  = ($urandom_range(0, 99) < 60);
            s.r1  = rnd_reg();
            s.d1  = $urandom;
            s.iv  = ($urandom_range(0, 99) < 40);
            s.ir  = rnd_reg();
            s.c1  = rnd_reg();
            s.c2  = rnd_reg();
            cyc(s);
        end

        repeat (3) cyc(idle());
        @(negedge clk);
        #1;
        chk("write_drain", 32'(wq.size()), 32'd0);
        chk("exp_drain",   32'(eq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regwb_arb.md
REGWB_ARB -- requirements
Module: regwb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive cycles requester 1 may be refused before it is forced a grant (legal range 1..7).
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wb0_valid  input  1  pipeline writeback request.
REQ-005 SHALL have port wb0_reg  input  5  pipeline destination register.
REQ-006 SHALL have port wb0_data  input  32  pipeline write data.
REQ-007 SHALL have port wb0_ready  output  1  pipeline request accepted this cycle.
REQ-008 SHALL have ports wb1_valid, wb1_reg, wb1_data, wb1_ready, with the same widths and meanings as the wb0 ports, for the multi-cycle unit or load unit.
REQ-009 SHALL have port iss_valid  input  1  an instruction with a pending register write issues this cycle.
REQ-010 SHALL have port iss_reg  input  5  destination register of the issuing instruction.
REQ-011 SHALL have ports chk_reg1, chk_reg2  input  5  source registers to hazard-check.
REQ-012 SHALL have ports chk_busy1, chk_busy2  output  1  the corresponding source register has an unresolved pending write.
REQ-013 SHALL have ports regwrite  output  1, wrreg  output  5, and wrdata  output  32, which drive the register file write port.

Function
REQ-014 Each requester's transfer SHALL complete when its valid and ready are both high at a rising edge.
REQ-015 At most one of wb0_ready and wb1_ready SHALL be high in any cycle.
REQ-016 Each ready SHALL be combinational from the valids and the starvation counter, and SHALL never depend on its own requester's data.
REQ-017 Grant rule, applied in this order:
  - wb1_valid and starve_cnt == STARVE_LIMIT: grant requester 1.
  - else wb0_valid: grant requester 0.
  - else wb1_valid: grant requester 1.
  - else: no grant.
REQ-018 starve_cnt SHALL be a 3-bit counter updated each edge as follows:
  - increment when wb1_valid is high and requester 1 is not granted;
  - saturate at STARVE_LIMIT;
  - clear to 0 when requester 1 is granted or wb1_valid is low.
REQ-019 Output registers SHALL load on the edge that accepts a transfer: regwrite = (accepted reg != 0), wrreg = that reg, wrdata = that data.
REQ-020 On edges with no accepted transfer, regwrite SHALL load 0, and wrreg and wrdata SHALL hold their values.
REQ-021 Write latency SHALL be one cycle: data accepted at edge N is presented to the register file during cycle N+1 and written at edge N+1.
REQ-022 A transfer targeting register 0 SHALL be accepted normally, but SHALL produce no regwrite and SHALL not alter the scoreboard.
REQ-023 Scoreboard: a 32-bit busy vector, with bit 0 hardwired to 0.
REQ-024 On an edge with iss_valid high and iss_reg != 0, busy[iss_reg] SHALL be set.
REQ-025 On an edge with regwrite high, busy[wrreg] SHALL be cleared.
REQ-026 When the set and the clear of REQ-024 and REQ-025 hit the same register on the same edge, the set SHALL win.
REQ-027 chk_busyN SHALL equal busy[chk_regN] AND NOT (regwrite AND wrreg == chk_regN), because the register file forwards the in-flight write.
REQ-028 chk_busyN SHALL be 0 whenever chk_regN == 0.
REQ-029 Issuing to a register that is already busy SHALL leave it busy; the block SHALL NOT count multiple pending writes per register.

Reset
REQ-030 While reset is high at an edge, the block SHALL clear: regwrite, wrreg, wrdata, starve_cnt, and every busy bit.
REQ-031 While reset is high, wb0_ready and wb1_ready SHALL be forced to 0; no transfer or issue SHALL be accepted in that cycle.
REQ-032 A transfer or write pending at reset assertion SHALL be discarded; nothing SHALL be written after reset deasserts unless newly requested.
REQ-033 The first accepted transfer SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-034 Single write scenario:
  - Stimulus: wb0_valid=1, wb0_reg=5, wb0_data=0xDEADBEEF for one cycle.
  - Required: wb0_ready=1 that cycle; next cycle regwrite=1, wrreg=5, wrdata=0xDEADBEEF; the cycle after, regwrite=0.
REQ-035 Starvation scenario:
  - Stimulus: wb0_valid and wb1_valid both held high continuously, STARVE_LIMIT=3.
  - Required: requester 0 granted 3 cycles, requester 1 granted in the 4th cycle, then the pattern repeats; wb1_ready is never high for 2 consecutive cycles.
REQ-036 Scoreboard scenario:
  - Stimulus: iss_valid=1, iss_reg=7; then chk_reg1=7; then wb1 writes reg 7.
  - Required: chk_busy1=1 until the cycle regwrite=1 with wrreg=7, in which chk_busy1=0; it stays 0 afterwards.
REQ-037 Simultaneous set/clear scenario:
  - Stimulus: reg 9 busy; regwrite=1, wrreg=9 in the same cycle as iss_valid=1, iss_reg=9.
  - Required: busy[9] remains 1 after the edge.
REQ-038 Register 0 scenario:
  - Stimulus: wb0 request to reg 0; also iss_reg=0.
  - Required: wb0_ready=1, regwrite stays 0, and chk_busy for reg 0 is always 0.
REQ-039 Reset mid-operation scenario:
  - Stimulus: busy bits for regs 3 and 4 set and a transfer just accepted; reset asserted for one cycle.
  - Required: next cycle regwrite=0, all chk_busy=0, starve_cnt=0.
